vga_timing_pipe: RTL and testbench
==================================

Name: vga_timing_pipe

Overview:
- Parametrised successor of the demo's inline VGA timing and dither logic, factored into a reusable core.
- Generates h/v counters, frame counter, line and frame strobes, and sync pulses with configurable polarity.
- Accepts per-pixel colour from an external shader with a known pipeline latency and aligns sync/blank to it.
- Applies generic N→M-bit ordered (Bayer) dithering with temporal toggle, plus frame-latched test-pattern modes.

Parameters:
H_DISPLAY, 1220, visible clocks per line
H_FRONT, 31, front porch clocks
H_SYNC, 183, hsync pulse clocks
H_BACK, 91, back porch clocks (H_TOTAL = sum = 1525)
V_DISPLAY, 480, visible lines
V_FRONT, 10, front porch lines
V_SYNC, 2, vsync lines
V_BACK, 33, back porch lines (V_TOTAL = 525)
HSYNC_POL, 0, asserted level of hsync
VSYNC_POL, 0, asserted level of vsync
IN_BITS, 6, shader colour width per channel
OUT_BITS, 2, DAC width per channel; D = IN_BITS-OUT_BITS, legal range 0..6
PIPE_STAGES, 2, shader latency in clocks, legal range 0..8
TEMPORAL, 1, XOR dither column index with frame[0]
FRAME_W, 11, frame counter width

Ports:
clk48  in  1  pixel clock
rst_n  in  1  synchronous active-low reset
pause_n  in  1  0 freezes frame counter
mode  in  2  0 shader, 1 colour bars, 2 dithered gradient, 3 white
h_count  out  11  current column, undelayed
v_count  out  10  current line, undelayed
frame  out  FRAME_W  frame counter
line_start  out  1  one-clock pulse at h_count==H_DISPLAY
frame_start  out  1  one-clock pulse at h_count==0 && v_count==0
r_in,g_in,b_in  in  IN_BITS each  colour for counters issued PIPE_STAGES clocks earlier
hsync  out  1  sync, aligned to colour outputs
vsync  out  1  sync, aligned to colour outputs
r_out,g_out,b_out  out  OUT_BITS each  registered dithered colour

Behaviour:
- Reset (rst_n=0 at a clk48 edge): h_count=0, v_count=0, frame=0, mode_q=0, delay line cleared, colour outputs 0, hsync/vsync deasserted (~POL), strobes 0.
- Reset mid-line or mid-frame aborts immediately; counting resumes at 0,0 the cycle after rst_n=1.
- h_count increments 0..H_TOTAL-1, then wraps to 0 and advances v_count.
- v_count wraps at V_TOTAL-1. At that wrap, frame += 1 if pause_n, else holds. Frame wraps modulo 2^FRAME_W.
- hsync is asserted for H_DISPLAY+H_FRONT ≤ h < H_DISPLAY+H_FRONT+H_SYNC; vsync uses the same rule on v. active = h<H_DISPLAY && v<V_DISPLAY.
- mode_q latches mode only in the cycle frame_start=1; changes mid-frame take effect at the next frame.
- Delay line of PIPE_STAGES registers carries {active, hsync, vsync, h[9:0], v[2:0], frame[0]}, so dither and test patterns use coordinates matching the incoming shader colour. One further output register follows.
- Total latency from counter value to pins is PIPE_STAGES+1 clocks.
- Dither threshold T (D bits) takes i=h[2:0]^{3{TEMPORAL&frame[0]}} and j=v[2:0], both delayed.
  - Sequence s = (i0^j0, i0, i1^j1, i1, i2^j2, i2); T = first D elements of s, concatenated MSB-first.
  - out = min(2^OUT_BITS-1, (c+T) >> D), with sum width IN_BITS+1. D=0 gives out=c.
- Channel sources by mode_q:
  - 0: r_in/g_in/b_in, dithered.
  - 1: r=h[4+:OUT], g=h[4+OUT+:OUT], b=h[4+2·OUT+:OUT], undithered.
  - 2: r=h[0+:IN], g=h[2+:IN], b=h[4+:IN], dithered.
  - 3: all ones, undithered.
- Delayed active=0 forces colour outputs to 0 regardless of mode.
- line_start and frame_start are undelayed, combinational from the counters and registered-consistent.

Decomposition:
- Package vga_pkg: default 640x480@60 timing constants for the 48 MHz demo clock, mode encodings (MODE_SHADER, MODE_BARS, MODE_GRAD, MODE_WHITE), and a function for the sync window.
- Sub-module bayer_dither (combinational, params IN_BITS/OUT_BITS; inputs c, i, j; output out), instantiated three times.

Test Plan:
- Small timing (H 8/2/2/2, V 4/1/1/1), rst_n released: h wraps at 13, v wraps at 6; hsync low for h∈{10,11} at pins PIPE_STAGES+1 clocks later.
- pause_n=0 across a frame wrap -> frame unchanged; pause_n=1 -> frame increments by exactly 1 per wrap; frame_start pulses once per frame.
- Mode 0, IN=6, OUT=2, r_in=63 -> r_out=3 everywhere; r_in=0 -> 0; r_in=24 -> 4x4 spatial average 1.5 (8 pixels at 1, 8 at 2).
- Mode 0, r_in=24, TEMPORAL=1 -> pixel at h=0,v=0 alternates output between consecutive frames.
- Mode changed 1→2 mid-frame -> pins still show bars until the next frame_start, then the gradient.
- Assert rst_n=0 mid-line at h=500 -> next cycle all outputs 0 and syncs deasserted; after release, h_count=0 and v_count=0.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - VGA timing defaults, mode encodings and shared pixel-pipe types
package vga_pkg;

  // 640x480@60 style timing stretched to a 48 MHz pixel clock
  localparam int DEF_H_DISPLAY = 1220;
  localparam int DEF_H_FRONT   = 31;
  localparam int DEF_H_SYNC    = 183;
  localparam int DEF_H_BACK    = 91;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  typedef enum logic [1:0] {
    MODE_SHADER = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_GRAD   = 2'd2,
    MODE_WHITE  = 2'd3
  } mode_e;

  // Per-pixel attributes that travel alongside the shader latency.
  // hs/vs are "asserted" flags, so an all-zero entry means blank with syncs idle.
  typedef struct packed {
    logic       active;
    logic       hs;
    logic       vs;
    logic [9:0] h;
    logic [2:0] v;
    logic       f0;
  } pix_t;

  // True while pos lies in [start, start+len).
  function automatic logic in_window(input int pos, input int start, input int len);
    return (pos >= start) && (pos < start + len);
  endfunction

endpackage

// File: rtl/bayer_dither.sv
// rtl/bayer_dither.sv - N to M bit ordered dither of one colour channel
module bayer_dither #(
  parameter int IN_BITS  = 6,
  parameter int OUT_BITS = 2
) (
  input  logic [IN_BITS-1:0]  c,
  input  logic [2:0]          i,
  input  logic [2:0]          j,
  output logic [OUT_BITS-1:0] out
);

  localparam int D = IN_BITS - OUT_BITS;

  generate
    if (D == 0) begin : g_pass
      assign out = c;
    end else begin : g_dith
      logic [D-1:0]       t;
      logic [IN_BITS:0]   sum;
      logic [OUT_BITS:0]  q;

      // Threshold: interleave (i^j, i) bit pairs from LSB pair upward, MSB-first
      always_comb begin
        t = '0;
        for (int k = 0; k < D; k++) begin
          t[D-1-k] = (k % 2 == 0) ? (i[k/2] ^ j[k/2]) : i[k/2];
        end
      end

      assign sum = {1'b0, c} + (IN_BITS+1)'(t);
      assign q   = sum[IN_BITS:D];
      assign out = q[OUT_BITS] ? {OUT_BITS{1'b1}} : q[OUT_BITS-1:0];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_pipe.sv
// rtl/vga_timing_pipe.sv - VGA counters, latency-aligned sync/blank and dithered colour out
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int H_DISPLAY   = DEF_H_DISPLAY,
  parameter int H_FRONT     = DEF_H_FRONT,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BACK      = DEF_H_BACK,
  parameter int V_DISPLAY   = DEF_V_DISPLAY,
  parameter int V_FRONT     = DEF_V_FRONT,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BACK      = DEF_V_BACK,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int IN_BITS     = 6,
  parameter int OUT_BITS    = 2,
  parameter int PIPE_STAGES = 2,
  parameter int TEMPORAL    = 1,
  parameter int FRAME_W     = 11
) (
  input  logic                clk48,
  input  logic                rst_n,
  input  logic                pause_n,
  input  logic [1:0]          mode,
  output logic [10:0]         h_count,
  output logic [9:0]          v_count,
  output logic [FRAME_W-1:0]  frame,
  output logic                line_start,
  output logic                frame_start,
  input  logic [IN_BITS-1:0]  r_in,
  input  logic [IN_BITS-1:0]  g_in,
  input  logic [IN_BITS-1:0]  b_in,
  output logic                hsync,
  output logic                vsync,
  output logic [OUT_BITS-1:0] r_out,
  output logic [OUT_BITS-1:0] g_out,
  output logic [OUT_BITS-1:0] b_out
);

  localparam int          H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int          V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);

  logic [10:0]         h_q, h_d;
  logic [9:0]          v_q, v_d;
  logic [FRAME_W-1:0]  frame_q, frame_d;
  mode_e               mode_q;
  pix_t                cur, dly;
  logic [2:0]          dith_i;
  logic [IN_BITS-1:0]  r_src, g_src, b_src;
  logic [OUT_BITS-1:0] r_dith, g_dith, b_dith;
  logic [OUT_BITS-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
  logic                hsync_q, vsync_q;

  assign h_count     = h_q;
  assign v_count     = v_q;
  assign frame       = frame_q;
  assign line_start  = (h_q == 11'(H_DISPLAY));
  assign frame_start = (h_q == '0) && (v_q == '0);

  // Raster advance: column, then line at end of line, then frame at end of frame
  always_comb begin
    h_d     = h_q + 11'd1;
    v_d     = v_q;
    frame_d = frame_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      if (v_q == V_LAST) begin
        v_d = '0;
        if (pause_n) frame_d = frame_q + FRAME_W'(1);
      end else begin
        v_d = v_q + 10'd1;
      end
    end
  end

  // Counter and frame-latched mode registers
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      h_q     <= '0;
      v_q     <= '0;
      frame_q <= '0;
      mode_q  <= MODE_SHADER;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      frame_q <= frame_d;
      if (frame_start) mode_q <= mode_e'(mode);
    end
  end

  // Attributes of the pixel the counters are issuing this cycle
  always_comb begin
    cur        = '0;
    cur.active = (int'(h_q) < H_DISPLAY) && (int'(v_q) < V_DISPLAY);
    cur.hs     = in_window(int'(h_q), H_DISPLAY + H_FRONT, H_SYNC);
    cur.vs     = in_window(int'(v_q), V_DISPLAY + V_FRONT, V_SYNC);
    cur.h      = h_q[9:0];
    cur.v      = v_q[2:0];
    cur.f0     = frame_q[0];
  end

  generate
    if (PIPE_STAGES == 0) begin : g_nodly
      assign dly = cur;
    end else begin : g_dly
      pix_t dl_q [PIPE_STAGES];

      // Match the shader latency so attributes line up with r_in/g_in/b_in
      always_ff @(posedge clk48) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE_STAGES; k++) dl_q[k] <= '0;
        end else begin
          dl_q[0] <= cur;
          for (int k = 1; k < PIPE_STAGES; k++) dl_q[k] <= dl_q[k-1];
        end
      end

      assign dly = dl_q[PIPE_STAGES-1];
    end
  endgenerate

  assign dith_i = dly.h[2:0] ^ {3{(TEMPORAL != 0) && dly.f0}};

  // Dither source: shader colour, or coordinate gradient in gradient mode
  always_comb begin
    r_src = r_in;
    g_src = g_in;
    b_src = b_in;
    if (mode_q == MODE_GRAD) begin
      r_src = IN_BITS'(dly.h);
      g_src = IN_BITS'(dly.h >> 2);
      b_src = IN_BITS'(dly.h >> 4);
    end
  end

  bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dith_r (.c(r_src), .i(dith_i), .j(dly.v), .out(r_dith));
  bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dith_g (.c(g_src), .i(dith_i), .j(dly.v), .out(g_dith));
  bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dith_b (.c(b_src), .i(dith_i), .j(dly.v), .out(b_dith));

  // Per-mode colour selection; blanking overrides everything
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (dly.active) begin
      case (mode_q)
        MODE_SHADER, MODE_GRAD: begin
          r_d = r_dith;
          g_d = g_dith;
          b_d = b_dith;
        end
        MODE_BARS: begin
          r_d = OUT_BITS'(dly.h >> 4);
          g_d = OUT_BITS'(dly.h >> (4 + OUT_BITS));
          b_d = OUT_BITS'(dly.h >> (4 + 2 * OUT_BITS));
        end
        default: begin
          r_d = '1;
          g_d = '1;
          b_d = '1;
        end
      endcase
    end
  end

  // Output register: colour and sync levels leave the block together
  always_ff @(posedge clk48) begin
    if (!rst_n) begin
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
    end else begin
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      hsync_q <= dly.hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= dly.vs ? VSYNC_POL : ~VSYNC_POL;
    end
  end

  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// tb/tb_vga_timing_pipe.sv - randomized bench for vga_timing_pipe against a raster reference model
module tb_vga_timing_pipe;

  typedef struct {bit valid; int h; int v; int f;} ctr_t;

  // unit 0 = small raster, unit 1 = wide raster
  int HD[2]   = '{8, 520};
  int HF[2]   = '{2, 4};
  int HSW[2]  = '{2, 8};
  int HB[2]   = '{2, 4};
  int VD[2]   = '{4, 4};
  int VF[2]   = '{1, 1};
  int VSW[2]  = '{1, 1};
  int VB[2]   = '{1, 1};
  int HP[2]   = '{0, 1};
  int VP[2]   = '{0, 0};
  int INB[2]  = '{6, 5};
  int OUTB[2] = '{2, 2};
  int PS[2]   = '{2, 0};
  int TMP[2]  = '{1, 0};
  int FW[2]   = '{3, 11};

  logic clk48 = 1'b0;
  logic rst_n = 1'b0;
  logic pause_n = 1'b1;
  logic [1:0] mode = 2'd0;
  logic [5:0] r0 = '0, g0 = '0, b0 = '0;
  logic [4:0] r1 = '0, g1 = '0, b1 = '0;
  logic [10:0] hc0, hc1;
  logic [9:0]  vc0, vc1;
  logic [2:0]  fr0;
  logic [10:0] fr1;
  logic ls0, fs0, hs0, vs0, ls1, fs1, hs1, vs1;
  logic [1:0] ro0, go0, bo0, ro1, go1, bo1;

  int n_chk = 0, n_pass = 0;
  string pfx = "";

  int mh[2], mv[2], mf[2], mmode[2], cyc[2];
  ctr_t hist[2][16];
  ctr_t last_d[2];
  int last_mode[2];
  int e_r[2], e_g[2], e_b[2], e_hs[2], e_vs[2];
  int cr[2], cg[2], cb[2];
  bit rand_col = 1'b1;
  bit record = 1'b0;
  bit count_fs = 1'b0;
  int fs_cnt = 0;
  int rec[2][4][4];

  always #5 clk48 = ~clk48;

  vga_timing_pipe #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .IN_BITS(6), .OUT_BITS(2),
    .PIPE_STAGES(2), .TEMPORAL(1), .FRAME_W(3)
  ) u_small (
    .clk48(clk48), .rst_n(rst_n), .pause_n(pause_n), .mode(mode),
    .h_count(hc0), .v_count(vc0), .frame(fr0), .line_start(ls0), .frame_start(fs0),
    .r_in(r0), .g_in(g0), .b_in(b0), .hsync(hs0), .vsync(vs0),
    .r_out(ro0), .g_out(go0), .b_out(bo0)
  );

  vga_timing_pipe #(
    .H_DISPLAY(520), .H_FRONT(4), .H_SYNC(8), .H_BACK(4),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .IN_BITS(5), .OUT_BITS(2),
    .PIPE_STAGES(0), .TEMPORAL(0), .FRAME_W(11)
  ) u_wide (
    .clk48(clk48), .rst_n(rst_n), .pause_n(pause_n), .mode(mode),
    .h_count(hc1), .v_count(vc1), .frame(fr1), .line_start(ls1), .frame_start(fs1),
    .r_in(r1), .g_in(g1), .b_in(b1), .hsync(hs1), .vsync(vs1),
    .r_out(ro1), .g_out(go1), .b_out(bo1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s%s: got %0d, expected %0d", pfx, tag, obs, exp);
  endtask

  // Ordered dither from the threshold-sequence rule, in plain integer arithmetic
  function automatic int dith(input int u, input int c, input int h, input int v, input int f);
    int d, i, j, t, s, mx;
    d  = INB[u] - OUTB[u];
    i  = h % 8;
    j  = v % 8;
    t  = 0;
    mx = (1 << OUTB[u]) - 1;
    if (TMP[u] != 0 && (f % 2) == 1) i = i ^ 7;
    for (int n = 0; n < d; n++) begin
      s = (n % 2 == 0) ? (((i >> (n/2)) & 1) ^ ((j >> (n/2)) & 1)) : ((i >> (n/2)) & 1);
      t = t * 2 + s;
    end
    s = (c + t) >> d;
    return (s > mx) ? mx : s;
  endfunction

  // Predict the pins after the coming edge, then advance the raster position
  task automatic model_step(input int u);
    ctr_t cur, d;
    int act, hsa, vsa, mx, hh, ht, vt;
    ht = HD[u] + HF[u] + HSW[u] + HB[u];
    vt = VD[u] + VF[u] + VSW[u] + VB[u];
    mx = (1 << OUTB[u]) - 1;
    if (!rst_n) begin
      mh[u] = 0; mv[u] = 0; mf[u] = 0; mmode[u] = 0; cyc[u] = 0;
      e_r[u] = 0; e_g[u] = 0; e_b[u] = 0;
      e_hs[u] = 1 - HP[u]; e_vs[u] = 1 - VP[u];
      last_d[u] = '{1'b0, 0, 0, 0};
      last_mode[u] = 0;
    end else begin
      cur = '{1'b1, mh[u], mv[u], mf[u]};
      hist[u][cyc[u] % 16] = cur;
      if (cyc[u] >= PS[u]) d = hist[u][(cyc[u] - PS[u]) % 16];
      else d = '{1'b0, 0, 0, 0};
      cyc[u]++;
      act = (d.valid && d.h < HD[u] && d.v < VD[u]) ? 1 : 0;
      hsa = (d.valid && d.h >= HD[u] + HF[u] && d.h < HD[u] + HF[u] + HSW[u]) ? 1 : 0;
      vsa = (d.valid && d.v >= VD[u] + VF[u] && d.v < VD[u] + VF[u] + VSW[u]) ? 1 : 0;
      e_hs[u] = hsa ? HP[u] : 1 - HP[u];
      e_vs[u] = vsa ? VP[u] : 1 - VP[u];
      hh = d.h % 1024;
      e_r[u] = 0; e_g[u] = 0; e_b[u] = 0;
      if (act != 0) begin
        case (mmode[u])
          0: begin
            e_r[u] = dith(u, cr[u], d.h, d.v, d.f);
            e_g[u] = dith(u, cg[u], d.h, d.v, d.f);
            e_b[u] = dith(u, cb[u], d.h, d.v, d.f);
          end
          1: begin
            e_r[u] = (hh >> 4) & mx;
            e_g[u] = (hh >> (4 + OUTB[u])) & mx;
            e_b[u] = (hh >> (4 + 2 * OUTB[u])) & mx;
          end
          2: begin
            e_r[u] = dith(u, hh % (1 << INB[u]), d.h, d.v, d.f);
            e_g[u] = dith(u, (hh >> 2) % (1 << INB[u]), d.h, d.v, d.f);
            e_b[u] = dith(u, (hh >> 4) % (1 << INB[u]), d.h, d.v, d.f);
          end
          default: begin
            e_r[u] = mx; e_g[u] = mx; e_b[u] = mx;
          end
        endcase
      end
      last_d[u] = d;
      last_mode[u] = mmode[u];
      if (mh[u] == 0 && mv[u] == 0) mmode[u] = int'(mode);
      mh[u]++;
      if (mh[u] == ht) begin
        mh[u] = 0;
        mv[u]++;
        if (mv[u] == vt) begin
          mv[u] = 0;
          if (pause_n) mf[u] = (mf[u] + 1) % (1 << FW[u]);
        end
      end
    end
  endtask

  task automatic cmp(input int u, input logic [31:0] hc, input logic [31:0] vc, input logic [31:0] fr,
                     input logic [31:0] ls, input logic [31:0] fs, input logic [31:0] r,
                     input logic [31:0] g, input logic [31:0] b, input logic [31:0] hs,
                     input logic [31:0] vs);
    pfx = (u == 0) ? "small " : "wide ";
    check_eq("h_count", hc, mh[u]);
    check_eq("v_count", vc, mv[u]);
    check_eq("frame", fr, mf[u]);
    check_eq("line_start", ls, (mh[u] == HD[u]) ? 1 : 0);
    check_eq("frame_start", fs, (mh[u] == 0 && mv[u] == 0) ? 1 : 0);
    check_eq("r_out", r, e_r[u]);
    check_eq("g_out", g, e_g[u]);
    check_eq("b_out", b, e_b[u]);
    check_eq("hsync", hs, e_hs[u]);
    check_eq("vsync", vs, e_vs[u]);
    if (u == 0 && record && last_d[0].valid && last_mode[0] == 0 && last_d[0].h < 4 && last_d[0].v < 4)
      rec[last_d[0].f % 2][last_d[0].v][last_d[0].h] = int'(r);
    if (u == 0 && count_fs && fs == 1) fs_cnt++;
    pfx = "";
  endtask

  task automatic step();
    if (rand_col) begin
      for (int u = 0; u < 2; u++) begin
        cr[u] = int'($urandom_range(0, (1 << INB[u]) - 1));
        cg[u] = int'($urandom_range(0, (1 << INB[u]) - 1));
        cb[u] = int'($urandom_range(0, (1 << INB[u]) - 1));
      end
    end
    r0 = 6'(cr[0]); g0 = 6'(cg[0]); b0 = 6'(cb[0]);
    r1 = 5'(cr[1]); g1 = 5'(cg[1]); b1 = 5'(cb[1]);
    for (int u = 0; u < 2; u++) model_step(u);
    @(posedge clk48);
    #1;
    cmp(0, hc0, vc0, fr0, ls0, fs0, ro0, go0, bo0, hs0, vs0);
    cmp(1, hc1, vc1, fr1, ls1, fs1, ro1, go1, bo1, hs1, vs1);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic wait_wide(input int h, input int v, input int limit, input string tag);
    int k;
    k = 0;
    while (!(hc1 == 11'(h) && vc1 == 10'(v)) && k < limit) begin
      step();
      k++;
    end
    check_eq(tag, 32'(hc1) + 32'(vc1) * 32'd4096, h + v * 4096);
  endtask

  task automatic set_colour(input int cs, input int cw);
    cr[0] = cs; cg[0] = cs; cb[0] = cs;
    cr[1] = cw; cg[1] = cw; cb[1] = cw;
  endtask

  initial begin
    int f0, n1, n2;
    set_colour(0, 0);

    // reset state
    rst_n = 1'b0;
    steps(3);
    check_eq("reset hsync small", hs0, 1);
    check_eq("reset hsync wide", hs1, 0);
    check_eq("reset vsync wide", vs1, 1);
    check_eq("reset r_out", ro0, 0);
    check_eq("reset frame", fr1, 0);

    // randomized traffic: modes, pause and shader colours all varying
    rst_n = 1'b1;
    rand_col = 1'b1;
    for (int k = 0; k < 7504; k++) begin
      if (k % 500 == 0) mode = 2'($urandom_range(0, 3));
      pause_n = ($urandom_range(0, 7) != 0);
      step();
    end

    // pause across exactly one small-frame wrap, then one counted wrap
    pause_n = 1'b0;
    f0 = int'(fr0);
    fs_cnt = 0;
    count_fs = 1'b1;
    steps(98);
    check_eq("pause holds frame", fr0, f0);
    pause_n = 1'b1;
    steps(98);
    count_fs = 1'b0;
    check_eq("frame increments once", fr0, (f0 + 1) % 8);
    check_eq("frame_start per frame", fs_cnt, 2);

    // constant shader colours: saturation, zero, then the mid-level dither pattern
    mode = 2'd0;
    rand_col = 1'b0;
    set_colour(63, 31);
    steps(3760);
    set_colour(0, 0);
    steps(200);
    set_colour(24, 24);
    steps(4);
    for (int p = 0; p < 2; p++)
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < 4; h++) rec[p][v][h] = 99;
    record = 1'b1;
    steps(300);
    record = 1'b0;
    for (int p = 0; p < 2; p++) begin
      n1 = 0;
      n2 = 0;
      for (int v = 0; v < 4; v++)
        for (int h = 0; h < 4; h++) begin
          if (rec[p][v][h] == 1) n1++;
          else if (rec[p][v][h] == 2) n2++;
        end
      check_eq("dither level-1 pixels", n1, 8);
      check_eq("dither level-2 pixels", n2, 8);
    end
    check_eq("temporal origin even frame", rec[0][0][0], 1);
    check_eq("temporal origin odd frame", rec[1][0][0], 2);

    // bars latched for a frame, switch to gradient mid-frame
    rand_col = 1'b1;
    mode = 2'd1;
    wait_wide(535, 6, 8000, "reach wide frame end");
    steps(200);
    mode = 2'd2;
    wait_wide(337, 1, 4000, "reach bars sample");
    check_eq("bars kept mid-frame r", ro1, 1);
    check_eq("bars kept mid-frame g", go1, 1);
    check_eq("bars kept mid-frame b", bo1, 1);
    step();
    wait_wide(337, 1, 4000, "reach gradient sample");
    check_eq("gradient next frame r", ro1, 2);
    check_eq("gradient next frame g", go1, 3);
    check_eq("gradient next frame b", bo1, 3);

    // reset mid-line
    wait_wide(500, 2, 4000, "reach h=500");
    rst_n = 1'b0;
    step();
    check_eq("mid-line reset r_out", ro1, 0);
    check_eq("mid-line reset g_out", go1, 0);
    check_eq("mid-line reset hsync", hs1, 0);
    check_eq("mid-line reset vsync", vs1, 1);
    check_eq("mid-line reset h_count", hc1, 0);
    check_eq("mid-line reset v_count", vc1, 0);
    check_eq("mid-line reset small hsync", hs0, 1);
    rst_n = 1'b1;
    step();
    check_eq("count resumes", hc1, 1);
    for (int k = 0; k < 1500; k++) begin
      if (k % 300 == 0) mode = 2'($urandom_range(0, 3));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
